fft_bitrev_reorder: RTL

- Output-reorder stage that sits directly downstream of the last radix-2 SDF stage in the FFT pipeline.
- The SDF chain emits each N-point frame in bit-reversed index order, possibly with idle gaps; this block buffers one frame and replays it in natural order as a gap-free burst.
- Uses a ping-pong pair of N-entry complex banks, so a new frame is written while the previous one drains.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_pingpong_ram.sv | 34 +++
 rtl/fft_bitrev_reorder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output-reorder stage: default widths,
// read-side state encoding and the index bit-reversal helper.
package fft_pkg;

  localparam int FP_WIDTH_DEFAULT = 64;
  localparam int LOGN_DEFAULT     = 8;
  localparam int BITREV_MAX_W     = 16;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_e;

  // Reverses the low 'width' bits of x; bits at or above 'width' come back as 0.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                     input int width);
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      for (int j = 0; j < BITREV_MAX_W; j++) begin
        if (i + j == width - 1) r[i] = x[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two N-entry complex banks, one synchronous write port and one registered
// read port; the bank select is the address MSB.
module fft_pingpong_ram #(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 2 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // NOTE: storage and its read register carry no reset so the array maps onto
  // block RAM; every entry is written before the drain that reads it.
  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    if (rd_en) rd_data_q <= mem[{rd_bank, rd_addr}];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Buffers bit-reversed FFT frames in a ping-pong RAM and replays them in natural
// order as gap-free bursts. Optional pass-through via FFT_BITREV_BYPASS_EN.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int FLOAT_PRECISION = FP_WIDTH_DEFAULT,
  parameter int logn            = LOGN_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef FFT_BITREV_BYPASS_EN
  input  logic                       bypass,
`endif
  input  logic                       in_valid,
  input  logic [FLOAT_PRECISION-1:0] di_re,
  input  logic [FLOAT_PRECISION-1:0] di_im,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [FLOAT_PRECISION-1:0] do_re,
  output logic [FLOAT_PRECISION-1:0] do_im,
  output logic                       busy
);

  localparam int W = FLOAT_PRECISION;

  logic byp;
`ifdef FFT_BITREV_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  logic [logn-1:0] wr_cnt_q, wr_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  rd_state_e       state_q, state_d;
  logic [logn-1:0] rd_cnt_q, rd_cnt_d;
  logic            rd_bank_q, rd_bank_d;
  logic            v1_q, v1_d, sop1_q, sop1_d, eop1_q, eop1_d, byp1_q, byp1_d;
  logic [W-1:0]    byp_re_q, byp_re_d, byp_im_q, byp_im_d;
  logic            out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [W-1:0]    do_re_q, do_re_d, do_im_q, do_im_d;

  logic            wr_en, frame_full, rd_en;
  logic [logn-1:0] wr_addr;
  logic [2*W-1:0]  rd_data;

  always_comb begin
    wr_en      = in_valid & ~byp;
    frame_full = wr_en & (&wr_cnt_q);
    wr_cnt_d   = in_valid ? wr_cnt_q + 1'b1 : wr_cnt_q;
    wr_bank_d  = wr_bank_q ^ frame_full;
    wr_addr    = logn'(bitrev(BITREV_MAX_W'(wr_cnt_q), logn));
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (frame_full) begin
          state_d   = R_DRAIN;
          rd_cnt_d  = '0;
          rd_bank_d = wr_bank_q;
        end
      end
      R_DRAIN: begin
        rd_en    = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (&rd_cnt_q) begin
          // A frame completing on the last read chains straight into the next drain.
          if (frame_full) rd_bank_d = wr_bank_q;
          else            state_d   = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    v1_d     = rd_en;
    sop1_d   = rd_en & (rd_cnt_q == '0);
    eop1_d   = rd_en & (&rd_cnt_q);
    byp1_d   = byp;
    byp_re_d = byp_re_q;
    byp_im_d = byp_im_q;
    if (byp) begin
      v1_d   = in_valid;
      sop1_d = in_valid & (wr_cnt_q == '0);
      eop1_d = in_valid & (&wr_cnt_q);
      if (in_valid) begin
        byp_re_d = di_re;
        byp_im_d = di_im;
      end
    end

    out_valid_d = v1_q;
    out_sop_d   = sop1_q;
    out_eop_d   = eop1_q;
    do_re_d     = do_re_q;
    do_im_d     = do_im_q;
    if (v1_q) begin
      do_re_d = byp1_q ? byp_re_q : rd_data[2*W-1:W];
      do_im_d = byp1_q ? byp_im_q : rd_data[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      state_q     <= R_IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      v1_q        <= 1'b0;
      sop1_q      <= 1'b0;
      eop1_q      <= 1'b0;
      byp1_q      <= 1'b0;
      byp_re_q    <= '0;
      byp_im_q    <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      do_re_q     <= '0;
      do_im_q     <= '0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      v1_q        <= v1_d;
      sop1_q      <= sop1_d;
      eop1_q      <= eop1_d;
      byp1_q      <= byp1_d;
      byp_re_q    <= byp_re_d;
      byp_im_q    <= byp_im_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      do_re_q     <= do_re_d;
      do_im_q     <= do_im_d;
    end
  end

  fft_pingpong_ram #(
    .WIDTH  (2 * W),
    .ADDR_W (logn)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_addr),
    .wr_data ({di_re, di_im}),
    .rd_en   (rd_en),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data)
  );

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign do_re     = do_re_q;
  assign do_im     = do_im_q;
  assign busy      = (wr_cnt_q != '0) | (state_q == R_DRAIN) | v1_q | out_valid_q;

  a_no_bank_collision: assert property (@(posedge clk) disable iff (rst)
    (state_q == R_DRAIN) |-> (wr_bank_q != rd_bank_q));

endmodule
